// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, PC step
// and FSM state encoding.
package fetch_stage_pkg;
  localparam int FS_PC_WIDTH = 32;
  localparam int FS_IWIDTH   = 32;
  localparam int FS_PC_STEP  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_stage_skid.sv
// Depth-1 skid buffer holding a {pc, instr} response that arrived while
// decode was stalled.
module fetch_skid #(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic [IWIDTH-1:0]   in_instr,
  output logic                full,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [IWIDTH-1:0]   out_instr
);
  logic                full_q, full_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [IWIDTH-1:0]   instr_q, instr_d;

  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d  = 1'b1;
      pc_d    = in_pc;
      instr_d = in_instr;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full      = full_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, one-cycle imem request/response
// tagging, depth-1 skid under decode stall, and the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                     PC_WIDTH = FS_PC_WIDTH,
  parameter int                     IWIDTH   = FS_IWIDTH,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
  input  logic                f_clk,
  input  logic                f_rst,
  input  logic                f_i_ce,
  input  logic                f_i_stall,
  input  logic                f_i_redirect,
  input  logic [PC_WIDTH-1:0] f_i_target,
  input  logic                f_i_flush,
  output logic                f_o_imem_req,
  output logic [PC_WIDTH-1:0] f_o_imem_addr,
  input  logic [IWIDTH-1:0]   f_i_imem_instr,
  output logic [PC_WIDTH-1:0] fs_ds_o_pc,
  output logic [IWIDTH-1:0]   fs_ds_o_instr,
  output logic                fs_ds_o_valid
);
  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] tag_q, tag_d;
  logic                infl_q, infl_d;
  logic [PC_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [IWIDTH-1:0]   ifid_instr_q, ifid_instr_d;
  logic                ifid_valid_q, ifid_valid_d;

  logic                discard, rsp_vld, imem_req;
  logic                skid_full, skid_push, skid_pop;
  logic [PC_WIDTH-1:0] skid_pc;
  logic [IWIDTH-1:0]   skid_instr;

  always_comb begin
    discard   = f_i_redirect | f_i_flush;
    imem_req  = (state_q == FETCH) & ~f_i_stall & ~skid_full & ~f_i_redirect & ~f_rst;
    rsp_vld   = infl_q & ~discard;
    skid_push = rsp_vld & f_i_stall;
    skid_pop  = skid_full & ~f_i_stall & ~discard;

    state_d = f_i_ce ? FETCH : IDLE;

    pc_d = pc_q;
    if (f_i_redirect)  pc_d = f_i_target;
    else if (imem_req) pc_d = pc_q + PC_WIDTH'(FS_PC_STEP);

    infl_d = imem_req;
    tag_d  = imem_req ? pc_q : tag_q;

    // Skid drains before a fresh response; without either the register bubbles.
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (!f_i_stall) begin
      if (skid_pop) begin
        ifid_pc_d    = skid_pc;
        ifid_instr_d = skid_instr;
        ifid_valid_d = 1'b1;
      end else if (rsp_vld) begin
        ifid_pc_d    = tag_q;
        ifid_instr_d = f_i_imem_instr;
        ifid_valid_d = 1'b1;
      end else begin
        ifid_valid_d = 1'b0;
      end
    end
    if (f_i_flush) ifid_valid_d = 1'b0;
  end

  always_ff @(posedge f_clk) begin
    if (f_rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      tag_q        <= '0;
      infl_q       <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tag_q        <= tag_d;
      infl_q       <= infl_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  fetch_skid #(.PC_WIDTH(PC_WIDTH), .IWIDTH(IWIDTH)) u_skid (
    .clk      (f_clk),
    .rst      (f_rst),
    .push     (skid_push),
    .pop      (skid_pop),
    .flush    (discard),
    .in_pc    (tag_q),
    .in_instr (f_i_imem_instr),
    .full     (skid_full),
    .out_pc   (skid_pc),
    .out_instr(skid_instr)
  );

  assign f_o_imem_req  = imem_req;
  assign f_o_imem_addr = pc_q;
  assign fs_ds_o_pc    = ifid_pc_q;
  assign fs_ds_o_instr = ifid_instr_q;
  assign fs_ds_o_valid = ifid_valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a monitor scores every IF/ID entry decode
// consumes against a queue of hand-computed {pc, instr} pairs.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0, stall = 1'b0, redirect = 1'b0, flush = 1'b0;
  logic [31:0] target = '0;
  logic        imem_req;
  logic [31:0] imem_addr, imem_instr = '0;
  logic [31:0] ds_pc, ds_instr;
  logic        ds_valid;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t exp_q[$];
  int   n_chk = 0, n_err = 0;

  fetch_stage #(.PC_WIDTH(32), .IWIDTH(32), .RESET_PC(32'h0)) dut (
    .f_clk         (clk),
    .f_rst         (rst),
    .f_i_ce        (ce),
    .f_i_stall     (stall),
    .f_i_redirect  (redirect),
    .f_i_target    (target),
    .f_i_flush     (flush),
    .f_o_imem_req  (imem_req),
    .f_o_imem_addr (imem_addr),
    .f_i_imem_instr(imem_instr),
    .fs_ds_o_pc    (ds_pc),
    .fs_ds_o_instr (ds_instr),
    .fs_ds_o_valid (ds_valid)
  );

  always #5 clk = ~clk;

  // Memory model: data one cycle after a request, junk otherwise.
  always @(posedge clk) imem_instr <= imem_req ? (32'h2000_0000 | imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back('{pc: pc, instr: instr});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Decode consumes the IF/ID entry in any valid, unstalled, non-reset cycle.
  always @(negedge clk) begin
    if (!rst && ds_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_ifid: got pc %h instr %h, expected nothing", ds_pc, ds_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ifid_pc", ds_pc, e.pc);
        chk("ifid_instr", ds_instr, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and start-up latency
    tick(1);
    chk("req_in_reset", {31'b0, imem_req}, 32'h0);
    tick(1);
    chk("rst_valid", {31'b0, ds_valid}, 32'h0);
    chk("rst_pc", ds_pc, 32'h0);
    chk("rst_instr", ds_instr, 32'h0);
    rst = 1'b0; ce = 1'b1;
    #1 chk("req_after_reset", {31'b0, imem_req}, 32'h0);
    push(32'h0, 32'h2000_0000); push(32'h4, 32'h2000_0004); push(32'h8, 32'h2000_0008);
    push(32'hC, 32'h2000_000C); push(32'h10, 32'h2000_0010);
    tick(1);
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    tick(1);
    chk("valid_n1", {31'b0, ds_valid}, 32'h0);
    tick(1);
    chk("valid_n2", {31'b0, ds_valid}, 32'h1);
    chk("pc_n2", ds_pc, 32'h0);
    // Stall three cycles with PC 12 in flight
    tick(2);
    stall = 1'b1;
    tick(1);
    chk("hold_pc8", ds_pc, 32'h8);
    chk("skid_full", {31'b0, dut.skid_full}, 32'h1);
    chk("no_req_stalled", {31'b0, imem_req}, 32'h0);
    tick(2);
    stall = 1'b0;
    #1 chk("no_req_drain", {31'b0, imem_req}, 32'h0);
    tick(1);
    chk("skid_drained_pc", ds_pc, 32'hC);
    // Redirect while stalled with skid full; PC 20 is dropped
    push(32'h40, 32'h2000_0040); push(32'h48, 32'h2000_0048);
    tick(2);
    stall = 1'b1;
    tick(1);
    redirect = 1'b1; target = 32'h40;
    tick(1);
    redirect = 1'b0; stall = 1'b0;
    tick(2);
    chk("redir_pc", ds_pc, 32'h40);
    chk("redir_instr", ds_instr, 32'h2000_0040);
    // Flush coincident with the 0x44 response
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_valid", {31'b0, ds_valid}, 32'h0);
    // Wrap at the top of the address space
    push(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    tick(1);
    redirect = 1'b1; target = 32'hFFFF_FFFC;
    tick(1);
    redirect = 1'b0;
    tick(1);
    #1 chk("wrap_req", {31'b0, imem_req}, 32'h1);
    chk("wrap_addr", imem_addr, 32'h0);
    // Reset with PC 4 outstanding; its response must never appear
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("midrst_valid", {31'b0, ds_valid}, 32'h0);
    chk("midrst_pc", ds_pc, 32'h0);
    chk("midrst_req", {31'b0, imem_req}, 32'h0);
    rst = 1'b0;
    push(32'h0, 32'h2000_0000); push(32'h4, 32'h2000_0004); push(32'h8, 32'h2000_0008);
    // Drop ce with a response in flight; it still reaches IF/ID
    tick(3);
    ce = 1'b0;
    tick(1);
    #1 chk("idle_no_req", {31'b0, imem_req}, 32'h0);
    tick(1);
    chk("idle_deliver_valid", {31'b0, ds_valid}, 32'h1);
    chk("idle_deliver_pc", ds_pc, 32'h8);
    tick(3);
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
